// File: rtl/io_interconnect.sv
// Round-robin arbiter putting one core I/O request per cycle onto the shared bus; response 2 cycles after grant.
// Backpressure: ungranted cores hold via ii_ready; responses have no flow control (consumer always accepts).
module io_interconnect #(
  parameter int NUM_CORES        = 4,
  parameter int CORE_ID_WIDTH    = 2,
  parameter int THREAD_IDX_WIDTH = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_CORES-1:0]                       ior_request_valid,
  input  logic [NUM_CORES-1:0]                       ior_request_store,
  input  logic [NUM_CORES-1:0][THREAD_IDX_WIDTH-1:0] ior_request_thread_idx,
  input  logic [NUM_CORES-1:0][31:0]                 ior_request_address,
  input  logic [NUM_CORES-1:0][31:0]                 ior_request_value,
  output logic [NUM_CORES-1:0]                       ii_ready,
  output logic                                       ii_response_valid,
  output logic [CORE_ID_WIDTH-1:0]                   ii_response_core,
  output logic [THREAD_IDX_WIDTH-1:0]                ii_response_thread_idx,
  output logic [31:0]                                ii_response_read_value,
  output logic                                       io_bus_write_en,
  output logic                                       io_bus_read_en,
  output logic [31:0]                                io_bus_address,
  output logic [31:0]                                io_bus_write_data,
  input  logic [31:0]                                io_bus_read_data
);

  typedef struct packed {
    logic                        vld;
    logic [CORE_ID_WIDTH-1:0]    core;
    logic [THREAD_IDX_WIDTH-1:0] thread_idx;
  } stage1_t;

  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  logic                     grant_vld;
  logic [CORE_ID_WIDTH-1:0] grant_idx;
  stage1_t                  stage1;

  // rr_ptr names the highest-priority core: the one after the last grant.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_vld && !reset && ior_request_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CORE_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    ii_ready = '0;
    if (grant_vld) ii_ready[grant_idx] = 1'b1;
  end

  assign io_bus_write_en   = grant_vld &&  ior_request_store[grant_idx];
  assign io_bus_read_en    = grant_vld && !ior_request_store[grant_idx];
  assign io_bus_address    = ior_request_address[grant_idx];
  assign io_bus_write_data = ior_request_value[grant_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr                 <= '0;
      stage1                 <= '0;
      ii_response_valid      <= 1'b0;
      ii_response_core       <= '0;
      ii_response_thread_idx <= '0;
      ii_response_read_value <= '0;
    end else begin
      if (grant_vld)
        rr_ptr <= (grant_idx == CORE_ID_WIDTH'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      stage1.vld             <= grant_vld;
      stage1.core            <= grant_idx;
      stage1.thread_idx      <= ior_request_thread_idx[grant_idx];
      // Slave returns read data the cycle after the bus cycle, i.e. while stage1 holds it.
      ii_response_valid      <= stage1.vld;
      ii_response_core       <= stage1.core;
      ii_response_thread_idx <= stage1.thread_idx;
      ii_response_read_value <= io_bus_read_data;
    end
  end

endmodule

// File: tb/tb_io_interconnect.sv
// Randomized bench for io_interconnect with a queue-based response scoreboard.
module tb_io_interconnect;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int TW = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_vld;
  logic [N-1:0]          req_store;
  logic [N-1:0][TW-1:0]  req_thr;
  logic [N-1:0][31:0]    req_addr;
  logic [N-1:0][31:0]    req_val;
  logic [N-1:0]          ii_ready;
  logic                  ii_response_valid;
  logic [CW-1:0]         ii_response_core;
  logic [TW-1:0]         ii_response_thread_idx;
  logic [31:0]           ii_response_read_value;
  logic                  io_bus_write_en;
  logic                  io_bus_read_en;
  logic [31:0]           io_bus_address;
  logic [31:0]           io_bus_write_data;
  logic [31:0]           io_bus_read_data;

  io_interconnect #(.NUM_CORES(N), .CORE_ID_WIDTH(CW), .THREAD_IDX_WIDTH(TW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ior_request_valid      (req_vld),
    .ior_request_store      (req_store),
    .ior_request_thread_idx (req_thr),
    .ior_request_address    (req_addr),
    .ior_request_value      (req_val),
    .ii_ready               (ii_ready),
    .ii_response_valid      (ii_response_valid),
    .ii_response_core       (ii_response_core),
    .ii_response_thread_idx (ii_response_thread_idx),
    .ii_response_read_value (ii_response_read_value),
    .io_bus_write_en        (io_bus_write_en),
    .io_bus_read_en         (io_bus_read_en),
    .io_bus_address         (io_bus_address),
    .io_bus_write_data      (io_bus_write_data),
    .io_bus_read_data       (io_bus_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    int          thr;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference state: last granted core and the grant waiting for its read data.
  int   last_grant = N - 1;
  bit   pend_vld = 1'b0;
  int   pend_core = 0;
  int   pend_thr = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: compares every cycle against the head of the scoreboard.
  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("resp_valid", 32'(ii_response_valid), 32'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      chk("resp_core", 32'(ii_response_core), 32'(e.core));
      chk("resp_thread", 32'(ii_response_thread_idx), 32'(e.thr));
      chk("resp_read_value", ii_response_read_value, e.rdata);
    end
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
  end

  // One clock cycle with the current inputs; entered #1 after a rising edge.
  task automatic step(input bit fix_rd = 1'b0, input logic [31:0] rd_val = 32'h0);
    int          g;
    int          idx;
    logic [31:0] rd;
    logic [N-1:0] exp_rdy;
    rd = fix_rd ? rd_val : $urandom;
    io_bus_read_data = rd;
    if (reset) begin
      sb.delete();
      pend_vld   = 1'b0;
      last_grant = N - 1;
      g          = -1;
    end else begin
      if (pend_vld) sb.push_back('{pend_core, pend_thr, rd, cyc + 1});
      g = -1;
      for (int off = 1; off <= N; off++) begin
        idx = (last_grant + off) % N;
        if (g < 0 && req_vld[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clk);
    chk("ii_ready", 32'(ii_ready), 32'(exp_rdy));
    chk("write_en", 32'(io_bus_write_en), 32'(g >= 0 && req_store[g]));
    chk("read_en", 32'(io_bus_read_en), 32'(g >= 0 && !req_store[g]));
    if (g >= 0) begin
      chk("address", io_bus_address, req_addr[g]);
      if (req_store[g]) chk("write_data", io_bus_write_data, req_val[g]);
      pend_vld   = 1'b1;
      pend_core  = g;
      pend_thr   = int'(req_thr[g]);
      last_grant = g;
    end else begin
      pend_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    req_vld[i]   = 1'b1;
    req_store[i] = 1'($urandom_range(0, 1));
    req_thr[i]   = TW'($urandom);
    req_addr[i]  = $urandom;
    req_val[i]   = $urandom;
  endtask

  initial begin
    reset            = 1'b1;
    req_vld          = '1;
    req_store        = '0;
    req_thr          = '0;
    req_addr         = '0;
    req_val          = '0;
    io_bus_read_data = '0;
    @(posedge clk);
    #1;
    // Valids held high through reset must not be granted.
    step();
    step();
    chk("rst_resp_core", 32'(ii_response_core), 32'd0);
    chk("rst_resp_thread", 32'(ii_response_thread_idx), 32'd0);
    chk("rst_resp_read_value", ii_response_read_value, 32'd0);
    reset   = 1'b0;
    req_vld = '0;
    for (int k = 0; k < 3; k++) step();

    // Directed store then load on core 0.
    req_vld[0] = 1'b1; req_store[0] = 1'b1; req_thr[0] = 2'd1;
    req_addr[0] = 32'h1234; req_val[0] = 32'h5f168902;
    step();
    req_vld = '0;
    step(); step(); step();
    req_vld[0] = 1'b1; req_store[0] = 1'b0; req_thr[0] = 2'd2;
    req_addr[0] = 32'h5678;
    step();
    req_vld = '0;
    step(1'b1, 32'h1d483d36);
    step(); step();

    // All cores continuously valid: grants rotate, each granted core replaces its request.
    for (int i = 0; i < N; i++) new_req(i);
    for (int k = 0; k < 3 * N; k++) begin
      step();
      new_req(pend_core);
    end
    req_vld = '0;
    step(); step(); step();

    // Back-to-back loads from cores 1 and 2.
    new_req(1); req_store[1] = 1'b0;
    new_req(2); req_store[2] = 1'b0;
    step();
    req_vld[pend_core] = 1'b0;
    step();
    req_vld = '0;
    step(); step(); step();

    // Reset one cycle after a grant: the response must never appear.
    new_req(3);
    step();
    req_vld = '0;
    reset   = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Randomized traffic obeying the hold-until-granted protocol.
    for (int k = 0; k < 3000; k++) begin
      if (pend_vld) req_vld[pend_core] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req_vld[i] && $urandom_range(0, 2) != 0) new_req(i);
      step();
    end
    req_vld = '0;
    for (int k = 0; k < 4; k++) step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
